// File: rtl/alu_secuencial_if.sv
// Operand/result bundle for the sequential ALU.
// The master side issues operations; the slave side executes them.
interface alu_secuencial_if #(
    parameter int N = 8
) ();
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [2:0]   selector;
    logic         operacion;
    logic         start;
    logic [N-1:0] out;
    logic         cout;
    logic         zero;
    logic         negativo;
    logic         overflow;
    logic         ocupado;
    logic         listo;

    modport master (
        output A, B, selector, operacion, start,
        input  out, cout, zero, negativo, overflow, ocupado, listo
    );

    modport slave (
        input  A, B, selector, operacion, start,
        output out, cout, zero, negativo, overflow, ocupado, listo
    );
endinterface

// File: rtl/alu_secuencial.sv
// Clocked ALU: single-cycle logic/add/sub/shift, bit-serial MUL/DIV/MOD.
// Results and flags are registered and only change with listo.
module alu_secuencial #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_secuencial_if.slave  bus
);
    localparam int SW = $clog2(N);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [N-1:0]  ONE  = N'(1);

    typedef enum logic {
        S_IDLE,
        S_CALC
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [1:0]     r_mop;
    logic [2*N-1:0] r_acc;
    logic [N-1:0]   r_rem;
    logic [N-1:0]   r_q;

    logic [N-1:0]   r_out;
    logic           r_cout;
    logic           r_zero;
    logic           r_neg;
    logic           r_ovf;
    logic           r_ocupado;
    logic           r_listo;

    logic [SW-1:0]  w_sh;
    logic           w_multi;
    logic [N-1:0]   w_x;
    logic [N-1:0]   w_y;
    logic           w_cin;
    logic [N:0]     w_sum;
    logic [N-1:0]   w_res;
    logic           w_c;
    logic           w_v;
    logic           w_upd_out;

    logic [2*N-1:0] w_prod_nxt;
    logic           w_ge;
    logic [N-1:0]   w_diff;
    logic [N-1:0]   w_rem_nxt;
    logic [N-1:0]   w_q_nxt;
    logic [N-1:0]   w_fres;
    logic           w_fc;
    logic           w_fv;

    assign w_sh    = bus.B[SW-1:0];
    assign w_multi = bus.operacion &&
                     (bus.selector == 3'b100 ||
                      bus.selector == 3'b101 ||
                      bus.selector == 3'b110);

    // Single-cycle datapath; SUB/DEC/CMP add the inverted operand plus one
    always_comb begin
        w_x       = bus.A;
        w_y       = '0;
        w_cin     = 1'b0;
        w_res     = '0;
        w_c       = 1'b0;
        w_v       = 1'b0;
        w_upd_out = 1'b1;
        w_sum     = '0;
        if (!bus.operacion) begin
            case (bus.selector)
                3'b000:  w_res = bus.A & bus.B;
                3'b001:  w_res = bus.A | bus.B;
                3'b010:  w_res = bus.A ^ bus.B;
                3'b011:  w_res = ~bus.A;
                3'b100:  w_res = bus.A << w_sh;
                3'b101:  w_res = bus.A >> w_sh;
                3'b110:  w_res = ~(bus.A & bus.B);
                default: w_res = ~(bus.A | bus.B);
            endcase
        end else begin
            case (bus.selector)
                3'b000: w_y = bus.B;
                3'b001: begin
                    w_y   = ~bus.B;
                    w_cin = 1'b1;
                end
                3'b010: w_y = ONE;
                3'b011: begin
                    w_y   = ~ONE;
                    w_cin = 1'b1;
                end
                3'b111: begin
                    w_y       = ~bus.B;
                    w_cin     = 1'b1;
                    w_upd_out = 1'b0;
                end
                default: w_y = '0;
            endcase
            w_sum = {1'b0, w_x} + {1'b0, w_y} + {{N{1'b0}}, w_cin};
            w_res = w_sum[N-1:0];
            w_c   = w_sum[N];
            w_v   = (w_x[N-1] == w_y[N-1]) && (w_sum[N-1] != w_x[N-1]);
        end
    end

    // One multiply/divide step per cycle
    always_comb begin
        w_prod_nxt = r_acc;
        if (r_b[r_cnt]) begin
            w_prod_nxt = r_acc + ({{N{1'b0}}, r_a} << r_cnt);
        end
        w_ge      = {r_rem, r_q[N-1]} >= {1'b0, r_b};
        w_diff    = {r_rem[N-2:0], r_q[N-1]} - r_b;
        w_rem_nxt = w_ge ? w_diff : {r_rem[N-2:0], r_q[N-1]};
        w_q_nxt   = {r_q[N-2:0], w_ge};
    end

    always_comb begin
        w_fres = w_prod_nxt[N-1:0];
        w_fc   = 1'b0;
        w_fv   = 1'b0;
        case (r_mop)
            2'b00: begin
                w_fres = w_prod_nxt[N-1:0];
                w_fc   = |w_prod_nxt[2*N-1:N];
            end
            2'b01: begin
                w_fres = w_q_nxt;
                w_fv   = (r_b == '0);
            end
            default: begin
                w_fres = w_rem_nxt;
                w_fv   = (r_b == '0);
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_mop     <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_out     <= '0;
            r_cout    <= 1'b0;
            r_zero    <= 1'b0;
            r_neg     <= 1'b0;
            r_ovf     <= 1'b0;
            r_ocupado <= 1'b0;
            r_listo   <= 1'b0;
        end else begin
            r_listo <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (w_multi) begin
                            r_a       <= bus.A;
                            r_b       <= bus.B;
                            r_mop     <= bus.selector[1:0];
                            r_acc     <= '0;
                            r_rem     <= '0;
                            r_q       <= bus.A;
                            r_cnt     <= '0;
                            r_ocupado <= 1'b1;
                            r_state   <= S_CALC;
                        end else begin
                            if (w_upd_out) begin
                                r_out <= w_res;
                            end
                            r_cout  <= w_c;
                            r_ovf   <= w_v;
                            r_zero  <= (w_res == '0);
                            r_neg   <= w_res[N-1];
                            r_listo <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_acc <= w_prod_nxt;
                    r_rem <= w_rem_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_out     <= w_fres;
                        r_cout    <= w_fc;
                        r_ovf     <= w_fv;
                        r_zero    <= (w_fres == '0);
                        r_neg     <= w_fres[N-1];
                        r_listo   <= 1'b1;
                        r_ocupado <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.out      = r_out;
    assign bus.cout     = r_cout;
    assign bus.zero     = r_zero;
    assign bus.negativo = r_neg;
    assign bus.overflow = r_ovf;
    assign bus.ocupado  = r_ocupado;
    assign bus.listo    = r_listo;
endmodule

// File: tb/tb_alu_secuencial.sv
// Bench for alu_secuencial: arithmetic reference model checked every cycle
// plus directed vectors with hand-computed results.
module tb_alu_secuencial;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_secuencial_if #(.N(N)) bus ();
    alu_secuencial #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int out;
        int c;
        int z;
        int n;
        int v;
    } res_t;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sgn(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    function automatic res_t ref_alu(input int op, input int sel, input int a,
                                     input int b, input int prev);
        res_t r;
        int t, sh, sa, sb;
        r  = '{default: 0};
        sa = sgn(a);
        sb = sgn(b);
        sh = b % 8;
        t  = 0;
        if (op == 0) begin
            case (sel)
                0: t = a & b;
                1: t = a | b;
                2: t = a ^ b;
                3: t = ~a & 255;
                4: t = (a << sh) & 255;
                5: t = a >> sh;
                6: t = ~(a & b) & 255;
                default: t = ~(a | b) & 255;
            endcase
        end else begin
            case (sel)
                0: begin
                    t = (a + b) & 255;
                    r.c = (a + b > 255);
                    r.v = (sa + sb > 127 || sa + sb < -128);
                end
                2: begin
                    t = (a + 1) & 255;
                    r.c = (a == 255);
                    r.v = (sa + 1 > 127);
                end
                3: begin
                    t = (a - 1) & 255;
                    r.c = (a >= 1);
                    r.v = (sa - 1 < -128);
                end
                4: begin
                    t = (a * b) & 255;
                    r.c = (a * b > 255);
                end
                5: begin
                    t = (b == 0) ? 255 : a / b;
                    r.v = (b == 0);
                end
                6: begin
                    t = (b == 0) ? a : a % b;
                    r.v = (b == 0);
                end
                default: begin
                    t = (a - b) & 255;
                    r.c = (a >= b);
                    r.v = (sa - sb > 127 || sa - sb < -128);
                end
            endcase
        end
        r.out = (op == 1 && sel == 7) ? prev : t;
        r.z = (t == 0);
        r.n = (t >> 7) & 1;
        return r;
    endfunction

    res_t m_r, m_pend, m_tmp;
    int   m_left = 0;
    int   m_listo = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_r     = '{default: 0};
            m_pend  = '{default: 0};
            m_left  = 0;
            m_listo = 0;
        end else begin
            m_listo = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_r     = m_pend;
                    m_listo = 1;
                end
            end else if (bus.start === 1'b1) begin
                m_tmp = ref_alu(int'(bus.operacion), int'(bus.selector),
                                int'(bus.A), int'(bus.B), m_r.out);
                if (bus.operacion && bus.selector >= 3'd4 && bus.selector <= 3'd6) begin
                    m_pend = m_tmp;
                    m_left = N;
                end else begin
                    m_r     = m_tmp;
                    m_listo = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("listo", int'(bus.listo), m_listo);
            chk("ocupado", int'(bus.ocupado), int'(m_left > 0));
            chk("out", int'(bus.out), m_r.out);
            chk("cout", int'(bus.cout), m_r.c);
            chk("zero", int'(bus.zero), m_r.z);
            chk("neg", int'(bus.negativo), m_r.n);
            chk("ovf", int'(bus.overflow), m_r.v);
        end
    end

    task automatic lit(input string nm, input int o, input int c, input int z,
                       input int n, input int v);
        chk({nm, "_out"}, int'(bus.out), o);
        chk({nm, "_c"}, int'(bus.cout), c);
        chk({nm, "_z"}, int'(bus.zero), z);
        chk({nm, "_n"}, int'(bus.negativo), n);
        chk({nm, "_v"}, int'(bus.overflow), v);
    endtask

    task automatic issue(input int op, input int sel, input int a, input int b,
                         output int lat, output int busy);
        @(negedge clk);
        bus.operacion = op[0];
        bus.selector  = sel[2:0];
        bus.A         = a[7:0];
        bus.B         = b[7:0];
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat  = 1;
        busy = int'(bus.ocupado);
        while (!bus.listo && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.ocupado) busy++;
        end
        chk("listo_seen", int'(bus.listo), 1);
    endtask

    int lat, busy, lc;
    int t_op[12]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
    int t_sel[12] = '{0, 1, 2, 3, 5, 6, 0, 2, 3, 4, 6, 4};
    int t_a[12]   = '{'h3C, 'h3C, 'h3C, 'h3C, 'h81, 'hFF, 'h7F, 'hFF, 'h00, 'hFF, 'h33, 'h01};
    int t_b[12]   = '{'h0F, 'h0F, 'h0F, 'h00, 'h04, 'h0F, 'h01, 'h00, 'h00, 'hFF, 'h00, 'h0F};
    int t_exp[12] = '{'h0C, 'h3F, 'h33, 'hC3, 'h08, 'hF0, 'h80, 'h00, 'hFF, 'h01, 'h33, 'h80};
    int b_op[4]   = '{0, 1, 0, 1};
    int b_sel[4]  = '{0, 0, 2, 2};
    int b_a[4]    = '{'h0F, 'h10, 'hAA, 'h41};
    int b_b[4]    = '{'h3C, 'h20, 'hFF, 'h00};
    int b_exp[4]  = '{'h0C, 'h30, 'h55, 'h42};

    initial begin
        bus.A = '0;
        bus.B = '0;
        bus.selector = '0;
        bus.operacion = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        lit("reset", 0, 0, 0, 0, 0);
        chk("reset_busy", int'(bus.ocupado), 0);
        chk("reset_listo", int'(bus.listo), 0);
        rst = 1'b0;
        chk_en = 1'b1;

        issue(1, 0, 'hFF, 'h01, lat, busy);
        chk("add_lat", lat - 1, 0);
        lit("add", 'h00, 1, 1, 0, 0);
        issue(1, 1, 'h80, 'h01, lat, busy);
        lit("sub", 'h7F, 1, 0, 0, 1);
        issue(1, 7, 'h05, 'h09, lat, busy);
        chk("cmp_out", int'(bus.out), 'h7F);
        chk("cmp_c", int'(bus.cout), 0);
        chk("cmp_n", int'(bus.negativo), 1);

        issue(1, 4, 'h0F, 'h11, lat, busy);
        chk("mul_lat", lat - 1, 8);
        chk("mul_busy", busy, 8);
        lit("mul1", 'hFF, 0, 0, 1, 0);
        issue(1, 4, 'h10, 'h10, lat, busy);
        lit("mul2", 'h00, 1, 1, 0, 0);

        issue(1, 5, 'hC8, 'h07, lat, busy);
        chk("div_out", int'(bus.out), 'h1C);
        issue(1, 6, 'hC8, 'h07, lat, busy);
        chk("mod_out", int'(bus.out), 'h04);
        issue(1, 5, 'h33, 'h00, lat, busy);
        chk("div0_lat", lat - 1, 8);
        lit("div0", 'hFF, 0, 0, 1, 1);

        issue(0, 4, 'h81, 'h03, lat, busy);
        chk("shl_out", int'(bus.out), 'h08);
        issue(0, 7, 'hF0, 'h0F, lat, busy);
        chk("nor_out", int'(bus.out), 'h00);
        chk("nor_z", int'(bus.zero), 1);

        for (int i = 0; i < 12; i++) begin
            issue(t_op[i], t_sel[i], t_a[i], t_b[i], lat, busy);
            chk($sformatf("vec%0d_out", i), int'(bus.out), t_exp[i]);
        end

        lc = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.operacion = b_op[i][0];
            bus.selector  = b_sel[i][2:0];
            bus.A         = b_a[i][7:0];
            bus.B         = b_b[i][7:0];
            bus.start     = 1'b1;
            @(negedge clk);
            if (bus.listo) lc++;
            chk($sformatf("b2b%0d_out", i), int'(bus.out), b_exp[i]);
        end
        bus.start = 1'b0;
        @(negedge clk);
        chk("b2b_count", lc, 4);
        chk("b2b_idle", int'(bus.listo), 0);

        bus.operacion = 1'b1;
        bus.selector  = 3'd4;
        bus.A = 8'h0F;
        bus.B = 8'h11;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.operacion = 1'b0;
        bus.selector  = 3'd2;
        bus.A = 8'hFF;
        bus.B = 8'h00;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A = 8'h00;
        lat = 0;
        while (!bus.listo && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        lit("busy_mul", 'hFF, 0, 0, 1, 0);

        @(negedge clk);
        bus.operacion = 1'b1;
        bus.selector  = 3'd4;
        bus.A = 8'h10;
        bus.B = 8'h10;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        lit("rst_mid", 0, 0, 0, 0, 0);
        chk("rst_busy", int'(bus.ocupado), 0);
        chk("rst_listo", int'(bus.listo), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.operacion = 1'b1;
        bus.selector  = 3'd0;
        bus.A = 8'h02;
        bus.B = 8'h03;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("post_rst_listo", int'(bus.listo), 1);
        lit("post_rst", 'h05, 0, 0, 0, 0);
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
